// File: rtl/mul_sched_if.sv
// Bundle of request, multiplier and result signals between mul_sched and its surroundings.
// Handshakes: a request is taken when reqN and gntN are both high in a cycle; a result is taken when out_valid and out_ready are both high at a rising edge.
interface mul_sched_if #(
  parameter int TAG_W = 5
);
  logic             req0;
  logic             req1;
  logic [31:0]      a0;
  logic [31:0]      b0;
  logic [31:0]      a1;
  logic [31:0]      b1;
  logic [TAG_W-1:0] tag0;
  logic [TAG_W-1:0] tag1;
  logic             gnt0;
  logic             gnt1;
  logic             flush;
  logic             fu_en;
  logic [31:0]      fu_a;
  logic [31:0]      fu_b;
  logic [31:0]      fu_res;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  modport slave (
    input  req0, req1, a0, b0, a1, b1, tag0, tag1, flush, fu_res, out_ready,
    output gnt0, gnt1, fu_en, fu_a, fu_b, out_valid, out_data, out_tag, busy
  );

  modport master (
    output req0, req1, a0, b0, a1, b1, tag0, tag1, flush, fu_res, out_ready,
    input  gnt0, gnt1, fu_en, fu_a, fu_b, out_valid, out_data, out_tag, busy
  );
endinterface

// File: rtl/mul_sched.sv
// Two-requester round-robin scheduler for a single non-pipelined multiplier.
// One operation in flight: issue, wait LATENCY cycles, hold the product until the consumer accepts it.
module mul_sched #(
  parameter int LATENCY = 7,
  parameter int TAG_W   = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  mul_sched_if.slave   bus,
  output logic [1:0]   state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             last_q, last_d;
  logic [31:0]      fa_q, fb_q;
  logic [31:0]      data_q;
  logic [TAG_W-1:0] tag_q;
  logic             issue;
  logic             capture;
  logic             win;

  // win selects requester 1; on a tie the one not granted last goes first
  always_comb begin
    if (bus.req0 && bus.req1) win = ~last_q;
    else                      win = bus.req1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    issue   = 1'b0;
    capture = 1'b0;
    if (bus.flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          // rst_n gate keeps grants low while reset is asserted
          if (rst_n && (bus.req0 || bus.req1)) begin
            issue   = 1'b1;
            state_d = EXEC;
            cnt_d   = 4'(LATENCY - 1);
            last_d  = win;
          end
        end
        EXEC: begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            capture = 1'b1;
            state_d = DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      fa_q    <= '0;
      fb_q    <= '0;
      data_q  <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      if (issue) begin
        fa_q  <= win ? bus.a1 : bus.a0;
        fb_q  <= win ? bus.b1 : bus.b0;
        tag_q <= win ? bus.tag1 : bus.tag0;
      end
      if (capture) data_q <= bus.fu_res;
    end
  end

  // Operands go straight through in the issue cycle and are held afterwards
  assign bus.gnt0      = issue & ~win;
  assign bus.gnt1      = issue & win;
  assign bus.fu_en     = issue;
  assign bus.fu_a      = issue ? (win ? bus.a1 : bus.a0) : fa_q;
  assign bus.fu_b      = issue ? (win ? bus.b1 : bus.b0) : fb_q;
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = data_q;
  assign bus.out_tag   = tag_q;
  assign bus.busy      = (state_q != IDLE);
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_mul_sched.sv
// Bench for mul_sched: directed scenarios plus random traffic against a timestamp-based reference model
// and a scoreboard of expected {tag, product} results.
module tb_mul_sched;
  localparam int LATENCY = 7;
  localparam int TAG_W   = 5;
  localparam int W       = 32 + TAG_W;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] state_dbg;

  mul_sched_if #(.TAG_W(TAG_W)) bus ();

  mul_sched #(.LATENCY(LATENCY), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Multiplier environment: product is on fu_res only in the cycle the scheduler must sample it
  int          mul_cnt = 0;
  logic [31:0] mul_prod = '0;
  logic [31:0] junk = '0;
  always @(posedge clk) begin
    junk <= $urandom;
    if (bus.fu_en) begin
      mul_cnt  <= LATENCY - 1;
      mul_prod <= bus.fu_a * bus.fu_b;
    end else if (mul_cnt > 0) begin
      mul_cnt <= mul_cnt - 1;
    end
  end
  assign bus.fu_res = (mul_cnt == 1) ? mul_prod : junk;

  // Reference model: one operation at a time, result due LATENCY cycles after its issue cycle
  int          cyc = 0;
  bit          m_have = 1'b0;
  int          m_ready = 0;
  bit          m_last = 1'b1;
  logic [31:0] m_fa = '0;
  logic [31:0] m_fb = '0;
  always begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      m_have = 1'b0;
      m_last = 1'b1;
      m_fa   = '0;
      m_fb   = '0;
      exp_q.delete();
    end else begin
      bit          e_issue;
      bit          e_win;
      logic [31:0] pa, pb;
      logic [TAG_W-1:0] pt;
      cyc++;
      e_issue = !m_have && !bus.flush && (bus.req0 || bus.req1);
      e_win   = (bus.req0 && bus.req1) ? !m_last : bus.req1;
      pa = e_win ? bus.a1 : bus.a0;
      pb = e_win ? bus.b1 : bus.b0;
      pt = e_win ? bus.tag1 : bus.tag0;
      if (e_issue) begin
        m_fa = pa;
        m_fb = pb;
      end
      chk("gnt0", bus.gnt0, e_issue && !e_win);
      chk("gnt1", bus.gnt1, e_issue && e_win);
      chk("fu_en", bus.fu_en, e_issue);
      chk("fu_a", bus.fu_a, m_fa);
      chk("fu_b", bus.fu_b, m_fb);
      chk("busy", bus.busy, m_have);
      chk("out_valid", bus.out_valid, m_have && (cyc >= m_ready));
      if (bus.flush) begin
        m_have = 1'b0;
        exp_q.delete();
      end else if (e_issue) begin
        logic [31:0] prod;
        prod    = pa * pb;
        m_have  = 1'b1;
        m_ready = cyc + LATENCY;
        m_last  = e_win;
        exp_q.push_back({pt, prod});
      end else if (m_have && (cyc >= m_ready) && bus.out_ready) begin
        m_have = 1'b0;
      end
    end
  end

  // Result monitor: every presented result must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL out_unexpected: got data %0h tag %0h expected no result", bus.out_data, bus.out_tag);
      end else begin
        chk("out_data", bus.out_data, exp_q[0][31:0]);
        chk("out_tag", bus.out_tag, exp_q[0][W-1:32]);
        if (bus.out_ready && !bus.flush) void'(exp_q.pop_front());
      end
    end
  end

  // Driver
  bit g0, g1, ov;
  int ncyc = 0;
  bit glog[$];
  int gcyc[$];

  task automatic step();
    @(negedge clk);
    g0 = bus.gnt0;
    g1 = bus.gnt1;
    ov = bus.out_valid;
    ncyc++;
    if (g0 || g1) begin
      glog.push_back(g1);
      gcyc.push_back(ncyc);
    end
    @(posedge clk);
    #1;
    if (g0) bus.req0 = 1'b0;
    if (g1) bus.req1 = 1'b0;
  endtask

  task automatic set_req(input int n, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] t);
    if (n == 0) begin
      bus.req0 = 1'b1; bus.a0 = a; bus.b0 = b; bus.tag0 = t;
    end else begin
      bus.req1 = 1'b1; bus.a1 = a; bus.b1 = b; bus.tag1 = t;
    end
  endtask

  task automatic quiet(input int n);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    repeat (n) step();
  endtask

  task automatic wait_grant(input string name);
    int k = 0;
    do begin
      step();
      k++;
    end while (!(g0 || g1) && k < 20);
    chk(name, g0 || g1, 1'b1);
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    do begin
      step();
      k++;
    end while (!ov && k < 20);
    chk(name, ov, 1'b1);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_out_valid"}, bus.out_valid, 0);
    chk({name, "_busy"}, bus.busy, 0);
    chk({name, "_fu_en"}, bus.fu_en, 0);
    chk({name, "_gnt0"}, bus.gnt0, 0);
    chk({name, "_gnt1"}, bus.gnt1, 0);
    chk({name, "_out_data"}, bus.out_data, 0);
    chk({name, "_out_tag"}, bus.out_tag, 0);
    chk({name, "_fu_a"}, bus.fu_a, 0);
    chk({name, "_fu_b"}, bus.fu_b, 0);
  endtask

  initial begin
    int t0;
    rst_n = 1'b0;
    bus.req0 = 0; bus.req1 = 0;
    bus.a0 = 0; bus.b0 = 0; bus.a1 = 0; bus.b1 = 0;
    bus.tag0 = 0; bus.tag1 = 0;
    bus.flush = 0;
    bus.out_ready = 0;
    #2;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Tie straight after reset: requester 0 first, then alternation, 8 cycles per operation
    glog.delete();
    gcyc.delete();
    bus.out_ready = 1'b1;
    set_req(0, $urandom, $urandom, 5'($urandom));
    set_req(1, $urandom, $urandom, 5'($urandom));
    for (int i = 0; i < 40 && glog.size() < 3; i++) begin
      step();
      if (!bus.req0) set_req(0, $urandom, $urandom, 5'($urandom));
      if (!bus.req1) set_req(1, $urandom, $urandom, 5'($urandom));
    end
    chk("tie_grant_count", glog.size() >= 3, 1'b1);
    if (glog.size() >= 3) begin
      chk("tie_first", glog[0], 1'b0);
      chk("tie_second", glog[1], 1'b1);
      chk("tie_third", glog[2], 1'b0);
      chk("tie_spacing_a", gcyc[1] - gcyc[0], 8);
      chk("tie_spacing_b", gcyc[2] - gcyc[1], 8);
    end
    quiet(12);

    // Single operation 3*5 tag 4, result visible 7 cycles after the grant
    set_req(0, 3, 5, 4);
    wait_grant("single_grant");
    t0 = ncyc;
    wait_valid("single_valid");
    chk("single_latency", ncyc - t0, LATENCY);
    quiet(3);

    // Backpressure: result held for 5 cycles, waiting requester granted only after acceptance
    bus.out_ready = 1'b0;
    set_req(0, $urandom, $urandom, 5'($urandom));
    wait_valid("bp_valid");
    set_req(1, $urandom, $urandom, 5'($urandom));
    repeat (5) step();
    bus.out_ready = 1'b1;
    step();
    chk("bp_no_grant_on_accept", g1, 1'b0);
    step();
    chk("bp_grant_after_accept", g1, 1'b1);
    quiet(12);

    // Flush three cycles into an operation, new request right after
    set_req(0, $urandom, $urandom, 5'($urandom));
    wait_grant("flush_grant");
    step();
    step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    set_req(1, $urandom, $urandom, 5'($urandom));
    step();
    chk("flush_regrant", g1, 1'b1);
    quiet(12);

    // Reset in the middle of an operation, then all-ones times two
    set_req(0, $urandom, $urandom, 5'($urandom));
    wait_grant("rst_grant");
    repeat (3) step();
    set_req(1, 32'hFFFF_FFFF, 32'd2, 5'd7);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    step();
    rst_n = 1'b1;
    step();
    chk("post_reset_grant", g1, 1'b1);
    wait_valid("post_reset_valid");
    chk("post_reset_product", bus.out_data, 32'hFFFF_FFFE);
    quiet(3);

    // Flush and out_ready together while a result is waiting
    bus.out_ready = 1'b0;
    set_req(1, $urandom, $urandom, 5'($urandom));
    wait_valid("coll_valid");
    bus.flush = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    step();
    chk("coll_valid_dropped", ov, 1'b0);
    chk("coll_idle", bus.busy, 1'b0);
    quiet(3);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if (!bus.req0 && $urandom_range(0, 3) == 0) set_req(0, $urandom, $urandom, 5'($urandom));
      if (!bus.req1 && $urandom_range(0, 3) == 0) set_req(1, $urandom, $urandom, 5'($urandom));
      bus.flush = ($urandom_range(0, 19) == 0);
      bus.out_ready = $urandom_range(0, 1);
      step();
    end
    quiet(20);
    chk("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/mul_sched.md
MUL_SCHED -- requirements
Module: mul_sched

Interface
REQ-001 The block SHALL have parameter LATENCY, default 7, meaning the number of cycles from the multiplier enable pulse to a valid product on fu_res (legal range 2..15).
REQ-002 The block SHALL have parameter TAG_W, default 5, meaning the width of the destination tag carried with each operation.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req0 / req1  input  1 each  requester 0/1 holds a multiply operation.
REQ-006 a0, b0 / a1, b1  input  32 each  operands of requester 0/1.
REQ-007 tag0 / tag1  input  TAG_W each  destination tag of requester 0/1.
REQ-008 gnt0 / gnt1  output  1 each  combinational one-cycle grant; the requester drops its request the next cycle.
REQ-009 flush  input  1  kills the in-flight or pending operation.
REQ-010 fu_en  output  1  one-cycle enable pulse to the multiplier.
REQ-011 fu_a, fu_b  output  32 each  operands to the multiplier.
REQ-012 fu_res  input  32  low 32 bits of the product from the multiplier.
REQ-013 out_valid  output  1  result available.
REQ-014 out_ready  input  1  consumer (CDB) accepts the result.
REQ-015 out_data  output  32  registered product.
REQ-016 out_tag  output  TAG_W  tag of out_data.
REQ-017 busy  output  1  high in any state other than IDLE.

Function
REQ-018 The block SHALL implement the FSM IDLE -> EXEC -> DONE -> IDLE; the multiplier is non-pipelined, so at most one operation is in flight.
REQ-019 In IDLE, with flush=0 and any reqN=1, the block SHALL assert exactly one gnt in the same cycle, drive fu_en=1 and route the granted operands to fu_a/fu_b, then go to EXEC, latch the granted tag and load the counter with LATENCY-1.
REQ-020 Arbitration SHALL be round-robin: if both requests are high, the requester not granted last wins; a single request always wins.
REQ-021 The last-granted pointer SHALL reset to 1, so requester 0 wins the first tie.
REQ-022 Outside an issue cycle, fu_en and both gnt SHALL be 0 and fu_a/fu_b SHALL hold their last driven values.
REQ-023 In EXEC, the counter SHALL decrement each cycle.
REQ-024 On the edge where the counter equals 1 (issue edge + LATENCY cycles), the block SHALL capture fu_res into out_data and go to DONE.
REQ-025 out_valid SHALL be high in DONE only, with out_data and out_tag stable while out_valid=1 and out_ready=0.
REQ-026 In DONE, out_ready=1 SHALL return the FSM to IDLE at that edge.
REQ-027 No grant SHALL be given in the cycle a result is accepted; the earliest next issue is the following cycle.
REQ-028 Requests arriving outside IDLE SHALL be ignored (not queued); requesters keep req high until granted.
REQ-029 flush=1 in any state SHALL force IDLE at the next edge and suppress gnt and fu_en in that cycle.
REQ-030 A product from a flushed operation SHALL never be presented on out_valid.
REQ-031 flush and out_ready both high in DONE SHALL be treated as flush; the result is dropped.
REQ-032 out_data SHALL equal the low 32 bits of fu_res unchanged; no sign handling is performed in this block.

Reset
REQ-033 On rst_n=0, independently of clk, the FSM SHALL go to IDLE and the counter to 0; out_valid, fu_en, gnt0, gnt1 and busy SHALL be 0; out_data, out_tag, fu_a and fu_b SHALL be 0; the pointer SHALL be 1.
REQ-034 Reset mid-EXEC or mid-DONE SHALL abandon the operation; the first issue after release is at the first edge with rst_n=1.

Verification
REQ-035 Single operation: req0=1, a0=3, b0=5, tag0=4 in cycle T -> gnt0=1 and fu_en=1 in T, out_valid=1 from T+7 with out_data=15 and out_tag=4.
REQ-036 Tie: req0=req1=1 held -> grants alternate 0, 1, 0 across three operations with out_ready tied 1, and each operation takes 8 cycles issue-to-issue.
REQ-037 Backpressure: out_ready=0 for 5 cycles after out_valid -> out_valid, out_data and out_tag stay stable, busy=1, req1 is not granted until the cycle after the out_ready=1 edge.
REQ-038 Flush: flush=1 at T+3 of an operation -> IDLE at T+4, no out_valid ever; a new request at T+4 is granted and returns its own correct product.
REQ-039 Reset: rst_n pulsed low mid-EXEC -> all outputs 0 immediately; a post-reset operation 0xFFFF_FFFF * 2 yields 0xFFFF_FFFE.
REQ-040 Collision: flush=1 and out_ready=1 together in DONE -> the result is dropped, FSM in IDLE, out_valid=0 the next cycle.
